// File: rtl/des_pkg.sv
// Shared DES key-schedule constants and types: PC-1/PC-2 selection tables
// (DES bit numbering, 1 = MSB) and the per-round left-shift amounts.
package des_pkg;

  typedef logic [64:1] des_key_t;
  typedef logic [28:1] des_half_t;
  typedef logic [48:1] des_subkey_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  localparam int unsigned PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Entry i is the left-rotate amount that produces round i+1's C/D.
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

endpackage

// File: rtl/des_pc2.sv
// PC-2 permutation: selects 48 of the 56 C||D bits to form a round subkey.
// Pure wiring, shared with any future pipelined round engine.
module des_pc2
  import des_pkg::*;
(
  input  logic [56:1] cd_in,
  output logic [48:1] subkey_out
);

  always_comb begin
    // NOTE: give every combinational output a default before conditional/loop
    // assignment so no path leaves it unassigned and a latch gets inferred.
    subkey_out = '0;
    for (int j = 1; j <= 48; j++) begin
      subkey_out[49 - j] = cd_in[57 - PC2_TABLE[j - 1]];
    end
  end

endmodule

// File: rtl/des_subkey_gen.sv
// Sequential DES key schedule: loads a key, then presents K1..K16 (encrypt)
// or K16..K1 (decrypt) one subkey per SUBKEY_ACK handshake.
module des_subkey_gen
  import des_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [64:1] KEY_IN,
  input  logic        DECRYPT,
  input  logic        KEY_LOAD,
  input  logic        SUBKEY_ACK,
  output logic [48:1] SUBKEY_OUT,
  output logic        SUBKEY_VALID,
  output logic [4:1]  ROUND_NUM,
  output logic        SCHED_DONE
);

  sched_state_e state_q, state_d;
  des_half_t    c_q, c_d, d_q, d_d;
  logic [3:0]   step_q, step_d;
  logic [3:0]   round_q, round_d;
  logic         decrypt_q, decrypt_d;
  logic         done_q, done_d;

  logic [56:1]  cd0;
  des_half_t    c0, d0;
  logic [3:0]   next_round;
  logic         parity_unused;

  function automatic des_half_t rotl(input des_half_t h, input logic [1:0] amt);
    return (amt == 2'd2) ? {h[26:1], h[28:27]} : {h[27:1], h[28]};
  endfunction

  function automatic des_half_t rotr(input des_half_t h, input logic [1:0] amt);
    return (amt == 2'd2) ? {h[2:1], h[28:3]} : {h[1], h[28:2]};
  endfunction

  // PC-1 never selects the eight parity bits.
  assign parity_unused = ^{KEY_IN[57], KEY_IN[49], KEY_IN[41], KEY_IN[33],
                           KEY_IN[25], KEY_IN[17], KEY_IN[9],  KEY_IN[1]};

  always_comb begin
    cd0 = '0;
    for (int j = 1; j <= 56; j++) begin
      cd0[57 - j] = KEY_IN[65 - PC1_TABLE[j - 1]];
    end
  end

  assign c0         = cd0[56:29];
  assign d0         = cd0[28:1];
  assign next_round = round_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    step_d    = step_q;
    round_d   = round_q;
    decrypt_d = decrypt_q;
    done_d    = 1'b0;

    if (KEY_LOAD) begin
      // A load overrides any ACK in the same cycle, including the final one.
      state_d   = ST_RUN;
      decrypt_d = DECRYPT;
      step_d    = 4'd0;
      if (DECRYPT) begin
        c_d     = c0;
        d_d     = d0;
        round_d = 4'd15;
      end else begin
        c_d     = rotl(c0, SHIFT_SCHED[0]);
        d_d     = rotl(d0, SHIFT_SCHED[0]);
        round_d = 4'd0;
      end
    end else if (state_q == ST_RUN && SUBKEY_ACK) begin
      if (step_q == 4'd15) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        step_d = step_q + 4'd1;
        if (decrypt_q) begin
          // Undo the shift that produced the current round's C/D.
          c_d     = rotr(c_q, SHIFT_SCHED[round_q]);
          d_d     = rotr(d_q, SHIFT_SCHED[round_q]);
          round_d = round_q - 4'd1;
        end else begin
          c_d     = rotl(c_q, SHIFT_SCHED[next_round]);
          d_d     = rotl(d_q, SHIFT_SCHED[next_round]);
          round_d = next_round;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      c_q       <= '0;
      d_q       <= '0;
      step_q    <= '0;
      round_q   <= '0;
      decrypt_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      state_q   <= state_d;
      c_q       <= c_d;
      d_q       <= d_d;
      step_q    <= step_d;
      round_q   <= round_d;
      decrypt_q <= decrypt_d;
      done_q    <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd_in      ({c_q, d_q}),
    .subkey_out (SUBKEY_OUT)
  );

  assign SUBKEY_VALID = (state_q == ST_RUN);
  assign ROUND_NUM    = round_q;
  assign SCHED_DONE   = done_q;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Self-checking bench for des_subkey_gen: known vectors, full encrypt/decrypt
// passes, random back-pressure, reload, async reset and parity insensitivity.
module tb_des_subkey_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [64:1] KEY_IN;
  logic        DECRYPT;
  logic        KEY_LOAD;
  logic        SUBKEY_ACK;
  logic [48:1] SUBKEY_OUT;
  logic        SUBKEY_VALID;
  logic [4:1]  ROUND_NUM;
  logic        SCHED_DONE;

  des_subkey_gen dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .KEY_IN       (KEY_IN),
    .DECRYPT      (DECRYPT),
    .KEY_LOAD     (KEY_LOAD),
    .SUBKEY_ACK   (SUBKEY_ACK),
    .SUBKEY_OUT   (SUBKEY_OUT),
    .SUBKEY_VALID (SUBKEY_VALID),
    .ROUND_NUM    (ROUND_NUM),
    .SCHED_DONE   (SCHED_DONE)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference tables, DES bit numbering (1 = MSB).
  int pc1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                   10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                   16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                   44,49,39,56,34,53, 46,42,50,36,29,32};
  int sched [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] exp_ks [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Kn bit j = bit pc2[j] of (C0,D0) each rotated left by the cumulative shift.
  task automatic compute_model(input logic [63:0] key);
    bit cd0 [1:56];
    int tot, p, src;
    for (int j = 1; j <= 56; j++) cd0[j] = key[64 - pc1[j - 1]];
    tot = 0;
    for (int n = 0; n < 16; n++) begin
      tot += sched[n];
      for (int j = 1; j <= 48; j++) begin
        p = pc2[j - 1];
        if (p <= 28) src = ((p - 1 + tot) % 28) + 1;
        else         src = 29 + ((p - 29 + tot) % 28);
        exp_ks[n][48 - j] = cd0[src];
      end
    end
  endtask

  task automatic load(input logic [63:0] key, input logic dec, input logic ack);
    KEY_IN     = key;
    DECRYPT    = dec;
    KEY_LOAD   = 1'b1;
    SUBKEY_ACK = ack;
    tick();
    KEY_LOAD   = 1'b0;
  endtask

  // Load, hold ACK high, check all 16 subkeys against exp_ks and the done pulse.
  task automatic run_full(input logic [63:0] key, input logic dec, input string tag);
    int idx;
    load(key, dec, 1'b0);
    SUBKEY_ACK = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idx = dec ? 15 - i : i;
      check({tag, "_subkey"}, SUBKEY_OUT, exp_ks[idx]);
      check({tag, "_round"},  ROUND_NUM, idx);
      check({tag, "_valid"},  SUBKEY_VALID, 1'b1);
      check({tag, "_nodone"}, SCHED_DONE, 1'b0);
      tick();
    end
    check({tag, "_done"},      SCHED_DONE, 1'b1);
    check({tag, "_idle"},      SUBKEY_VALID, 1'b0);
    SUBKEY_ACK = 1'b0;
    tick();
    check({tag, "_done_1cyc"}, SCHED_DONE, 1'b0);
  endtask

  initial begin
    logic [63:0] key, key2;
    logic        dec;
    int          idx, cyc;
    bit          finished;
    logic        ack;

    RESET = 1'b1; KEY_IN = '0; DECRYPT = 1'b0; KEY_LOAD = 1'b0; SUBKEY_ACK = 1'b0;
    #1;
    check("rst_subkey", SUBKEY_OUT, 48'h0);
    check("rst_valid",  SUBKEY_VALID, 1'b0);
    check("rst_round",  ROUND_NUM, 4'd0);
    check("rst_done",   SCHED_DONE, 1'b0);
    tick(); tick();
    RESET = 1'b0;
    tick();
    check("post_rst_valid", SUBKEY_VALID, 1'b0);

    // Known-answer encrypt pass.
    key = 64'h133457799BBCDFF1;
    compute_model(key);
    check("model_k1_vec",  exp_ks[0],  48'h1B02EFFC7072);
    check("model_k16_vec", exp_ks[15], 48'hCB3D8B0E17F5);
    load(key, 1'b0, 1'b0);
    check("enc_k1_vec",    SUBKEY_OUT, 48'h1B02EFFC7072);
    check("enc_k1_round",  ROUND_NUM, 4'd0);
    SUBKEY_ACK = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("enc_k16_vec",   SUBKEY_OUT, 48'hCB3D8B0E17F5);
    check("enc_k16_round", ROUND_NUM, 4'd15);
    tick();
    check("enc_vec_done",  SCHED_DONE, 1'b1);
    SUBKEY_ACK = 1'b0;
    tick();

    // Known-answer decrypt pass endpoints, then full passes against the model.
    load(key, 1'b1, 1'b0);
    check("dec_first_vec",   SUBKEY_OUT, 48'hCB3D8B0E17F5);
    check("dec_first_round", ROUND_NUM, 4'd15);
    SUBKEY_ACK = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("dec_last_vec",    SUBKEY_OUT, 48'h1B02EFFC7072);
    check("dec_last_round",  ROUND_NUM, 4'd0);
    SUBKEY_ACK = 1'b0;
    tick();
    run_full(key, 1'b0, "enc");
    run_full(key, 1'b1, "dec");

    // Async reset mid-schedule.
    load(key, 1'b0, 1'b0);
    SUBKEY_ACK = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2 RESET = 1'b1;
    #1;
    check("midrst_subkey", SUBKEY_OUT, 48'h0);
    check("midrst_valid",  SUBKEY_VALID, 1'b0);
    check("midrst_round",  ROUND_NUM, 4'd0);
    check("midrst_done",   SCHED_DONE, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    tick(); tick();
    check("midrst_stay_idle",  SUBKEY_VALID, 1'b0);
    check("midrst_ack_ignored", ROUND_NUM, 4'd0);
    SUBKEY_ACK = 1'b0;

    // Random back-pressure, random key and direction.
    for (int pass = 0; pass < 3; pass++) begin
      key = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      compute_model(key);
      load(key, dec, 1'b0);
      idx = 0;
      finished = 0;
      for (cyc = 0; cyc < 200 && !finished; cyc++) begin
        check("bp_subkey", SUBKEY_OUT, exp_ks[dec ? 15 - idx : idx]);
        check("bp_round",  ROUND_NUM, dec ? 15 - idx : idx);
        ack = 1'($urandom_range(0, 1));
        SUBKEY_ACK = ack;
        tick();
        if (ack) begin
          if (idx == 15) begin
            check("bp_done",  SCHED_DONE, 1'b1);
            check("bp_idle",  SUBKEY_VALID, 1'b0);
            finished = 1;
          end else begin
            idx++;
          end
        end else begin
          check("bp_hold_nodone", SCHED_DONE, 1'b0);
        end
      end
      check("bp_finished_in_budget", finished, 1'b1);
      SUBKEY_ACK = 1'b0;
      tick();
    end

    // Reload together with ACK at step 7.
    key = {$urandom, $urandom};
    compute_model(key);
    load(key, 1'b0, 1'b0);
    SUBKEY_ACK = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("reload_pre_round",  ROUND_NUM, 4'd7);
    check("reload_pre_subkey", SUBKEY_OUT, exp_ks[7]);
    key2 = 64'h0123456789ABCDEF;
    load(key2, 1'b0, 1'b1);
    compute_model(key2);
    check("reload_k1",     SUBKEY_OUT, exp_ks[0]);
    check("reload_round",  ROUND_NUM, 4'd0);
    check("reload_nodone", SCHED_DONE, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("reload_k16", SUBKEY_OUT, exp_ks[15]);

    // Reload together with the final ACK: no done pulse, schedule restarts.
    load(key2, 1'b1, 1'b1);
    check("reload_last_nodone", SCHED_DONE, 1'b0);
    check("reload_last_valid",  SUBKEY_VALID, 1'b1);
    check("reload_last_round",  ROUND_NUM, 4'd15);
    check("reload_last_subkey", SUBKEY_OUT, exp_ks[15]);
    SUBKEY_ACK = 1'b0;
    tick();

    // Parity bits flipped: same subkeys as the unmodified key.
    key = {$urandom, $urandom};
    compute_model(key);
    run_full(key ^ 64'h0101010101010101, 1'b0, "parity_enc");
    run_full(key ^ 64'h0100010001000100, 1'b1, "parity_dec");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/des_subkey_gen.md
# des_subkey_gen

- Sequential DES key schedule generating the sixteen 48-bit round subkeys for the iterative round datapath that feeds the S-box ROMs.
- Supports both directions:
  - Encrypt order: K1..K16, using left rotations.
  - Decrypt order: K16..K1, using right rotations from the post-PC-1 state.
- Subkeys are presented one per handshake, so one key load serves a full 16-round pass.

## Interface
Parameters: none (tables fixed by FIPS 46-3).
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-high reset
- KEY_IN  in  [64:1]  64-bit DES key; bit 64 = DES bit 1 (MSB); parity bits ignored
- DECRYPT  in  1  sampled with KEY_LOAD; 1 = emit K16..K1, 0 = emit K1..K16
- KEY_LOAD  in  1  single-cycle strobe; captures KEY_IN/DECRYPT
- SUBKEY_ACK  in  1  consumer has taken current subkey; advance
- SUBKEY_OUT  out  [48:1]  current subkey, PC-2 output; bit 48 = DES bit 1
- SUBKEY_VALID  out  1  SUBKEY_OUT holds a valid subkey
- ROUND_NUM  out  [4:1]  round index of current subkey minus 1 (0 = K1, 15 = K16)
- SCHED_DONE  out  1  one-cycle pulse after the 16th subkey is acknowledged

## Operation
- State: 28-bit C and D registers, 4-bit step counter, direction flag.
- FSM has two states:
  - IDLE: SUBKEY_VALID = 0.
  - RUN: SUBKEY_VALID = 1.
- KEY_LOAD (any state) → RUN. Loading applies PC-1 to KEY_IN to form C0/D0.
  - Encrypt: C,D ← rotl1(C0), rotl1(D0); ROUND_NUM ← 0.
  - Decrypt: C,D ← C0, D0 (equal to C16/D16 because total shift is 28); ROUND_NUM ← 15.
- SUBKEY_OUT = PC-2(C‖D), driven from registered C/D. The combinational path after the registers is only PC-2 wiring.
- Shift schedule, indexed by round n=1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- SUBKEY_ACK in RUN with step < 15:
  - Encrypt: advance Kn → Kn+1 by rotating C and D left by shift[n+1]; ROUND_NUM += 1.
  - Decrypt: advance Kn → Kn-1 by rotating C and D right by shift[n]; ROUND_NUM −= 1.
- SUBKEY_ACK on the 16th subkey: → IDLE, SUBKEY_VALID ← 0, SCHED_DONE pulses 1 cycle.
- SUBKEY_ACK in IDLE: ignored.
- KEY_LOAD and SUBKEY_ACK in the same cycle: load wins and the schedule restarts. No SCHED_DONE is generated, even on the 16th subkey.
- In IDLE, C/D/ROUND_NUM hold their last values. SUBKEY_OUT is don't-care but stable.

## Timing
- Reset values: SUBKEY_OUT = 0, SUBKEY_VALID = 0, ROUND_NUM = 0, SCHED_DONE = 0, C/D = 0, state IDLE.
- KEY_LOAD at edge t → first subkey valid after edge t (1-cycle latency).
- ACK at edge t → next subkey presented after edge t. One subkey per cycle with ACK held high; 16 subkeys in 16 cycles.
- SUBKEY_OUT and ROUND_NUM change only on KEY_LOAD, on an accepted ACK, or on reset.
- Reset asserted mid-schedule: outputs go to reset values immediately (asynchronous). The consumer must reload.

## Structure
- Shared package des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries) as constant index arrays.
  - SHIFT_SCHED constant (16 × 2-bit).
  - Typedefs: des_key_t [64:1], des_half_t [28:1], des_subkey_t [48:1].
- One sub-module: des_pc2, a combinational 56→48 permutation. It is reused by any future pipelined round engine.
- PC-1 and rotations stay inline in des_subkey_gen.

## Test plan
- Reset check: assert RESET mid-RUN → all outputs 0 in the same cycle; SUBKEY_VALID stays 0 after release until KEY_LOAD.
- Encrypt, key 133457799BBCDFF1, ACK held high → first SUBKEY_OUT = 1B02EFFC7072 with ROUND_NUM = 0. The 16th = CB3D8B0E17F5 with ROUND_NUM = 15. SCHED_DONE pulses the cycle after the final ACK.
- Decrypt, same key → first subkey CB3D8B0E17F5 (ROUND_NUM 15), last 1B02EFFC7072 (ROUND_NUM 0). The full sequence is the exact reverse of the encrypt run, checked against a reference model.
- Back-pressure: ACK toggled randomly → SUBKEY_OUT and ROUND_NUM hold while ACK = 0. No subkey is skipped or repeated.
- Reload mid-schedule: KEY_LOAD together with ACK at step 7 using key 0123456789ABCDEF → schedule restarts at that key's K1, and SCHED_DONE does not pulse.
- Parity insensitivity: KEY_IN differing only in bits 57,49,...,1 (the parity positions) → identical subkey sequence.
